// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Controller-to-datapath bundle for the bit-serial subtractor.
// Handshake: start is taken on a rising edge only while the datapath is idle
// (busy=0, done=0); a/b are captured on that edge; done pulses once when
// diff/borrow_out/overflow become valid, and those hold until the next done.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full-subtractor cell: D = X - Y - Bin, Bout set when that goes negative.
module full_subtractor_s (
  input  logic X,
  input  logic Y,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  assign D    = X ^ Y ^ Bin;
  assign Bout = (~X & (Y | Bin)) | (Y & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single subtractor cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  serial_subtractor_if.slave    sub,
  output sub_state_t            state_dbg
);
  localparam int CW = $clog2(WIDTH) + 1;

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;
  logic             d_bit, bout_bit;

  full_subtractor_s u_cell (
    .X    (a_sh_q[0]),
    .Y    (b_sh_q[0]),
    .Bin  (borrow_q),
    .D    (d_bit),
    .Bout (bout_bit)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_sh_d    = diff_sh_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (sub.start) begin
          a_sh_d    = sub.a;
          b_sh_d    = sub.b;
          borrow_d  = 1'b0;
          cnt_d     = '0;
          diff_sh_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        diff_sh_d = {d_bit, diff_sh_q[WIDTH-1:1]};
        borrow_d  = bout_bit;
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d       = {d_bit, diff_sh_q[WIDTH-1:1]};
          borrow_out_d = bout_bit;
          // Signed overflow: borrow into the MSB differs from borrow out of it.
          overflow_d   = borrow_q ^ bout_bit;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_sh_q    <= diff_sh_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sub.busy       = (state_q == SHIFT);
  assign sub.done       = (state_q == DONE);
  assign sub.diff       = diff_q;
  assign sub.borrow_out = borrow_out_q;
  assign sub.overflow   = overflow_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  logic       clk;
  logic       reset_n;
  sub_state_t st8, st4;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [5:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .sub       (if8.slave),
    .state_dbg (st8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .sub       (if4.slave),
    .state_dbg (st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one 8-bit subtraction and check timing, stability and results.
  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e_diff, input logic e_bo, input logic e_ov);
    logic [7:0] prev;
    int         lat;
    int         busy_c;
    logic       stable;
    prev   = if8.diff;
    stable = 1'b1;
    lat    = -1;
    busy_c = 0;
    @(negedge clk);
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if8.start = 1'b0;
      if (if8.done) begin
        lat = n;
        break;
      end
      busy_c += int'(if8.busy);
      if (if8.diff !== prev) stable = 1'b0;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd8);
    check_eq({tag, "_busy_cycles"}, 32'(busy_c), 32'd8);
    check_eq({tag, "_diff_stable"}, {31'd0, stable}, 32'd1);
    check_eq({tag, "_busy_in_done"}, {31'd0, if8.busy}, 32'd0);
    check_eq({tag, "_diff"}, {24'd0, if8.diff}, {24'd0, e_diff});
    check_eq({tag, "_borrow"}, {31'd0, if8.borrow_out}, {31'd0, e_bo});
    check_eq({tag, "_ovf"}, {31'd0, if8.overflow}, {31'd0, e_ov});
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {31'd0, if8.done}, 32'd0);
  endtask

  // 4-bit op; expected value comes off the scoreboard queue at done.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b);
    logic [5:0] e;
    logic       seen;
    seen = 1'b0;
    @(negedge clk);
    if4.start = 1'b1;
    if4.a     = a;
    if4.b     = b;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if4.start = 1'b0;
      if (if4.done) begin
        seen = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check_eq("w4_timeout", 32'd0, 32'd1);
    end else begin
      check_eq("w4_diff", {28'd0, if4.diff}, {28'd0, e[3:0]});
      check_eq("w4_borrow", {31'd0, if4.borrow_out}, {31'd0, e[4]});
      check_eq("w4_ovf", {31'd0, if4.overflow}, {31'd0, e[5]});
    end
  endtask

  initial begin
    logic [7:0] a2, b2;
    logic [7:0] cap_diff;
    int         done_cnt;
    int         lat;
    logic       got;
    logic [3:0] dd;

    reset_n   = 1'b0;
    if8.start = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if4.start = 1'b0;
    if4.a     = '0;
    if4.b     = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check_eq("rst_state", {30'd0, st8}, {30'd0, IDLE});
    check_eq("rst_busy", {31'd0, if8.busy}, 32'd0);
    check_eq("rst_done", {31'd0, if8.done}, 32'd0);
    check_eq("rst_diff", {24'd0, if8.diff}, 32'd0);
    check_eq("rst_borrow", {31'd0, if8.borrow_out}, 32'd0);
    check_eq("rst_ovf", {31'd0, if8.overflow}, 32'd0);

    run_op8("sub_35_12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    run_op8("sub_12_35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    run_op8("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op8("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op8("sub_5a_5a", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);

    // start held high, operands scrambled every cycle
    @(negedge clk);
    if8.start = 1'b1;
    if8.a     = 8'h35;
    if8.b     = 8'h12;
    done_cnt  = 0;
    lat       = -1;
    cap_diff  = '0;
    a2        = '0;
    b2        = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (if8.done) begin
        done_cnt++;
        if (lat < 0) lat = n;
        cap_diff = if8.diff;
      end
      if (n == 9) check_eq("hold_idle_gap_busy", {31'd0, if8.busy}, 32'd0);
      a2     = 8'($urandom_range(0, 255));
      b2     = 8'($urandom_range(0, 255));
      if8.a  = a2;
      if8.b  = b2;
    end
    check_eq("hold_done_count", 32'(done_cnt), 32'd1);
    check_eq("hold_latency", 32'(lat), 32'd8);
    check_eq("hold_first_operands", {24'd0, cap_diff}, 32'h23);
    @(negedge clk);
    check_eq("hold_reaccept_k10", {31'd0, if8.busy}, 32'd1);
    if8.start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (if8.done) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("hold_second_done", {31'd0, got}, 32'd1);
    check_eq("hold_second_diff", {24'd0, if8.diff}, {24'd0, 8'(a2 - b2)});
    @(negedge clk);

    // reset asserted four edges into an operation (previous result is nonzero)
    @(negedge clk);
    if8.start = 1'b1;
    if8.a     = 8'h35;
    if8.b     = 8'h12;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_busy_before", {31'd0, if8.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, if8.busy}, 32'd0);
    check_eq("abort_done", {31'd0, if8.done}, 32'd0);
    check_eq("abort_diff", {24'd0, if8.diff}, 32'd0);
    check_eq("abort_borrow", {31'd0, if8.borrow_out}, 32'd0);
    check_eq("abort_ovf", {31'd0, if8.overflow}, 32'd0);
    check_eq("abort_state", {30'd0, st8}, {30'd0, IDLE});
    @(negedge clk);
    reset_n = 1'b1;
    run_op8("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

    // exhaustive 4-bit sweep against a behavioural model
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        dd = 4'(i - j);
        exp_q.push_back({(i[3] != j[3]) && (dd[3] != i[3]), (i < j), dd});
        run_op4(4'(i), 4'(j));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
